// File: rtl/program_loader_pkg.sv
// Shared types for the boot program loader.
//   loader_state_t : loader FSM states
//   BYTES_PER_WORD : bytes packed into one instruction word
//   word_t         : instruction word
package loader_pkg;

    typedef enum logic [2:0] {IDLE, LEN, LOAD, RUN, ERR} loader_state_t;

    localparam int BYTES_PER_WORD = 4;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/program_loader_if.sv
// Handshake/bus bundle between the loader, the UART receiver, instruction
// memory and the core.
//   start, rx_data, rx_valid        : boot request and incoming byte stream
//   imem_we, imem_addr, imem_wdata  : instruction memory write port
//   cpu_rst_n                       : core reset (0 holds the core)
//   pass_data, pass_valid           : post-program bytes forwarded to the core
//   busy, err                       : status
// Modports: slave = the loader, master = its environment.
interface program_loader_if #(
    parameter int INST_MEM_WIDTH = 14
);
    logic                      start;
    logic [7:0]                rx_data;
    logic                      rx_valid;
    logic                      imem_we;
    logic [INST_MEM_WIDTH-1:0] imem_addr;
    logic [31:0]               imem_wdata;
    logic                      cpu_rst_n;
    logic [7:0]                pass_data;
    logic                      pass_valid;
    logic                      busy;
    logic                      err;

    modport slave (
        input  start, rx_data, rx_valid,
        output imem_we, imem_addr, imem_wdata, cpu_rst_n,
               pass_data, pass_valid, busy, err
    );

    modport master (
        output start, rx_data, rx_valid,
        input  imem_we, imem_addr, imem_wdata, cpu_rst_n,
               pass_data, pass_valid, busy, err
    );
endinterface

// File: rtl/program_loader_word_packer.sv
// word_packer: shifts bytes in big-endian order and pulses word_valid for one
// cycle after the 4th byte of each group.
//   CLK, RST_N  : clock, synchronous active-low reset
//   clear       : restart the byte count (a byte arriving with clear becomes byte 0)
//   byte_data   : incoming byte
//   byte_valid  : byte_data strobe
//   word        : packed word (stable while word_valid is high)
//   word_valid  : one-cycle strobe, word complete
module word_packer
    import loader_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       clear,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output word_t      word,
    output logic       word_valid
);

    logic [1:0] byte_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            byte_cnt   <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                // A byte arriving on the LEN->LOAD handoff is the first program byte.
                byte_cnt <= byte_valid ? 2'd1 : 2'd0;
                if (byte_valid)
                    word <= {word[23:0], byte_data};
            end else if (byte_valid) begin
                // Shifting left puts the first byte of the group in [31:24].
                word       <= {word[23:0], byte_data};
                byte_cnt   <= byte_cnt + 2'd1;
                word_valid <= (byte_cnt == 2'(BYTES_PER_WORD - 1));
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// program_loader: boot sequencer. On start it reads a 4-byte big-endian word
// count N, packs the following bytes into N words written to instruction
// memory from address 0, then releases the core. Later bytes are forwarded
// to the core with one cycle of latency.
//   CLK, RST_N : clock, synchronous active-low reset
//   bus        : program_loader_if.slave (see interface for signal list)
// Build option: define PROGRAM_LOADER_TIMEOUT_EN to abort LEN/LOAD into ERR
// after TIMEOUT_CYCLES idle cycles between bytes.
module program_loader
    import loader_pkg::*;
#(
    parameter int INST_MEM_WIDTH = 14,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic             CLK,
    input  logic             RST_N,
    program_loader_if.slave  bus
);

    localparam word_t MAX_WORDS = word_t'(1) << INST_MEM_WIDTH;

    loader_state_t           state, state_next;
    word_t                   packed_word;
    logic                    packed_valid;
    logic [INST_MEM_WIDTH:0] word_cnt;    // index of the next word to write
    logic [INST_MEM_WIDTH:0] word_total;  // N, up to and including 2**INST_MEM_WIDTH
    logic                    start_ok, loading, len_done, last_write, timed_out;

    assign loading    = (state == LEN) || (state == LOAD);
    assign start_ok   = bus.start && (state == IDLE || state == RUN || state == ERR);
    assign len_done   = (state == LEN) && packed_valid;
    assign last_write = (state == LOAD) && packed_valid && (word_cnt == word_total - 1'b1);

    word_packer u_packer (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .clear     (start_ok || len_done),
        .byte_data (bus.rx_data),
        .byte_valid(bus.rx_valid && loading),
        .word      (packed_word),
        .word_valid(packed_valid)
    );

`ifdef PROGRAM_LOADER_TIMEOUT_EN
    logic [31:0] idle_cnt;

    always_ff @(posedge CLK) begin
        if (!RST_N)
            idle_cnt <= '0;
        else if (!loading || bus.rx_valid)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 32'd1;
    end

    assign timed_out = loading && !bus.rx_valid && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    // Never true: the idle timer is compiled out.
    assign timed_out = (TIMEOUT_CYCLES < 0);
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_N)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (bus.start) state_next = LEN;
            LEN: begin
                if (timed_out)
                    state_next = ERR;
                else if (packed_valid) begin
                    if (packed_word == '0)
                        state_next = RUN;
                    else if (packed_word > MAX_WORDS)
                        state_next = ERR;
                    else
                        state_next = LOAD;
                end
            end
            LOAD: begin
                if (timed_out)
                    state_next = ERR;
                else if (last_write)
                    state_next = RUN;
            end
            RUN, ERR: if (bus.start) state_next = LEN;
            default: state_next = IDLE;
        endcase
    end

    // Word counter and latched word count.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            word_cnt   <= '0;
            word_total <= '0;
        end else begin
            if (start_ok)
                word_cnt <= '0;
            else if ((state == LOAD) && packed_valid)
                word_cnt <= word_cnt + 1'b1;
            if (len_done)
                word_total <= packed_word[INST_MEM_WIDTH:0];
        end
    end

    // Post-program pass-through; start in the same cycle wins and drops the byte.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            bus.pass_valid <= 1'b0;
            bus.pass_data  <= '0;
        end else begin
            bus.pass_valid <= (state == RUN) && bus.rx_valid && !bus.start;
            if ((state == RUN) && bus.rx_valid && !bus.start)
                bus.pass_data <= bus.rx_data;
        end
    end

    // Output decode.
    always_comb begin
        bus.imem_we    = (state == LOAD) && packed_valid;
        bus.imem_addr  = word_cnt[INST_MEM_WIDTH-1:0];
        bus.imem_wdata = packed_word;
        bus.cpu_rst_n  = (state == RUN);
        bus.busy       = loading;
        bus.err        = (state == ERR);
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader. A transaction-level model turns
// each header/program byte list into the expected list of memory writes and
// forwarded bytes; monitors collect what the DUT actually does.
module tb_program_loader;

    localparam int AW  = 4;
    localparam int CAP = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    program_loader_if #(.INST_MEM_WIDTH(AW)) bus ();

    program_loader #(
        .INST_MEM_WIDTH(AW),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [63:0] got_wr[$];
    logic [63:0] exp_wr[$];
    logic [7:0]  got_pass[$];
    logic [7:0]  exp_pass[$];
    logic [7:0]  prog[$];

    // Monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1)
            got_wr.push_back({32'(bus.imem_addr), bus.imem_wdata});
        if (bus.pass_valid === 1'b1)
            got_pass.push_back(bus.pass_data);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        repeat ($urandom_range(0, max_gap)) tick();
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Start, send header n and all of prog; model the expected writes:
    // only a legal n writes, and only complete words of what was sent.
    task automatic run_load(input int n, input int max_gap);
        logic [31:0] hdr;
        hdr = 32'(n);
        pulse_start();
        for (int i = 0; i < 4; i++)
            send_byte(hdr[31-8*i -: 8], max_gap);
        if (n >= 1 && n <= CAP)
            for (int k = 0; k < n && 4*k+3 < prog.size(); k++)
                exp_wr.push_back({32'(k % CAP), prog[4*k], prog[4*k+1], prog[4*k+2], prog[4*k+3]});
        foreach (prog[i])
            send_byte(prog[i], max_gap);
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (bus.cpu_rst_n !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_run"}, 64'(bus.cpu_rst_n), 64'd1);
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_wr_count"}, 64'(got_wr.size()), 64'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), got_wr[i], exp_wr[i]);
        got_wr.delete();
        exp_wr.delete();
    endtask

    task automatic compare_pass(input string tag);
        check({tag, "_pass_count"}, 64'(got_pass.size()), 64'(exp_pass.size()));
        for (int i = 0; i < exp_pass.size() && i < got_pass.size(); i++)
            check($sformatf("%s_pass%0d", tag, i), 64'(got_pass[i]), 64'(exp_pass[i]));
        got_pass.delete();
        exp_pass.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},       64'(bus.busy),       64'd0);
        check({tag, "_err"},        64'(bus.err),        64'd0);
        check({tag, "_cpu_rst_n"},  64'(bus.cpu_rst_n),  64'd0);
        check({tag, "_imem_we"},    64'(bus.imem_we),    64'd0);
        check({tag, "_imem_addr"},  64'(bus.imem_addr),  64'd0);
        check({tag, "_imem_wdata"}, 64'(bus.imem_wdata), 64'd0);
        check({tag, "_pass_valid"}, 64'(bus.pass_valid), 64'd0);
        check({tag, "_pass_data"},  64'(bus.pass_data),  64'd0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_reset_outputs("reset");

        // Bytes in IDLE are dropped.
        send_byte(8'h99, 0);
        tick();
        compare_pass("idle_drop");

        // Two-word program; the 2nd write and the core release are cycle-exact.
        prog = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
        run_load(2, 0);
        check("t1_last_we",        64'(bus.imem_we),    64'd1);
        check("t1_last_addr",      64'(bus.imem_addr),  64'd1);
        check("t1_last_data",      64'(bus.imem_wdata), 64'h11223344);
        check("t1_hold_during_wr", 64'(bus.cpu_rst_n),  64'd0);
        check("t1_busy",           64'(bus.busy),       64'd1);
        tick();
        check("t1_release",        64'(bus.cpu_rst_n),  64'd1);
        check("t1_idle_busy",      64'(bus.busy),       64'd0);
        compare_writes("t1");

        // N == 0 goes straight to RUN.
        prog.delete();
        run_load(0, 0);
        tick();
        check("t2_release", 64'(bus.cpu_rst_n), 64'd1);
        compare_writes("t2");

        // Start in RUN re-enters LEN and holds the core next cycle.
        pulse_start();
        check("restart_hold", 64'(bus.cpu_rst_n), 64'd0);
        check("restart_busy", 64'(bus.busy),      64'd1);

        // N one beyond capacity -> ERR with no writes.
        run_load(CAP + 1, 0);
        tick();
        check("t3_err",  64'(bus.err),       64'd1);
        check("t3_hold", 64'(bus.cpu_rst_n), 64'd0);
        check("t3_busy", 64'(bus.busy),      64'd0);
        compare_writes("t3");
        send_byte(8'h42, 0);
        tick();
        compare_pass("err_drop");
        pulse_start();
        check("t3_err_cleared", 64'(bus.err),  64'd0);
        check("t3_restart",     64'(bus.busy), 64'd1);

        // Exactly capacity, random bytes and gaps.
        prog.delete();
        repeat (4 * CAP) prog.push_back(8'($urandom));
        run_load(CAP, 2);
        wait_run("full");
        compare_writes("full");

        // Pass-through latency, then start+byte together in RUN.
        send_byte(8'h5A, 0);
        check("t4_pass_valid", 64'(bus.pass_valid), 64'd1);
        check("t4_pass_data",  64'(bus.pass_data),  64'h5A);
        exp_pass.push_back(8'h5A);
        bus.start    = 1'b1;
        bus.rx_data  = 8'h77;
        bus.rx_valid = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        check("collide_no_pass", 64'(bus.pass_valid), 64'd0);
        check("collide_busy",    64'(bus.busy),       64'd1);
        tick();
        compare_pass("t4");

        // Reset after 6 of 8 data bytes: only word 0 is ever written.
        prog = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_load(2, 0);
        tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        check_reset_outputs("t5");
        send_byte(8'h07, 0);
        send_byte(8'h08, 0);
        repeat (3) tick();
        compare_writes("t5");
        compare_pass("t5");

        // Random programs followed by random pass-through traffic.
        for (int it = 0; it < 5; it++) begin
            int n;
            n = $urandom_range(1, CAP);
            prog.delete();
            repeat (4 * n) prog.push_back(8'($urandom));
            run_load(n, 2);
            wait_run($sformatf("rnd%0d", it));
            compare_writes($sformatf("rnd%0d", it));
            for (int j = 0; j < 3; j++) begin
                logic [7:0] b;
                b = 8'($urandom);
                exp_pass.push_back(b);
                send_byte(b, 2);
            end
            tick();
            compare_pass($sformatf("rnd%0d", it));
        end

`ifdef PROGRAM_LOADER_TIMEOUT_EN
        // Stall after 2 data bytes: ERR after 100 idle cycles.
        begin
            int n;
            prog = '{8'hDE, 8'hAD};
            run_load(2, 0);
            n = 0;
            while (bus.err !== 1'b1 && n < 150) begin
                tick();
                n++;
            end
            check("t6_err",         64'(bus.err), 64'd1);
            check("t6_idle_cycles", 64'(n),       64'd100);
            compare_writes("t6");
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
